// File: rtl/bus_timer_pkg.sv
// Shared types and constants for the bus-attached timer.
// Holds package Types_pkg: bus word types, register indices, CTRL/STATUS
// bit positions, the handshake state enum and the byte-lane merge helper.
package Types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  wstrobe_t;
    typedef logic [1:0]  reg_idx_t;

    // Register index as decoded from address[3:2]
    localparam reg_idx_t REG_CTRL   = 2'd0;
    localparam reg_idx_t REG_LIMIT  = 2'd1;
    localparam reg_idx_t REG_COUNT  = 2'd2;
    localparam reg_idx_t REG_STATUS = 2'd3;

    // CTRL bit positions
    localparam int CTRL_ENABLE      = 0;
    localparam int CTRL_IRQ_EN      = 1;
    localparam int CTRL_AUTO_RELOAD = 2;
    localparam int CTRL_PRESC_LSB   = 8;
    localparam int CTRL_PRESC_MSB   = 15;

    // STATUS bit positions
    localparam int STATUS_EVENT     = 0;

    // Largest COUNT value; the counter never passes it except through a match
    localparam word_t COUNT_MAX = 32'hFFFF_FFFF;

    // Bus handshake states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    // Replace the byte lanes of cur selected by strb with those of wdata
    function automatic word_t merge_lanes(word_t cur, word_t wdata, wstrobe_t strb);
        word_t res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_if.sv
// Simple valid/ready register bus.
// Handshake: the requester raises valid with address/wstrobe/wdata; the
// responder answers with ready high for exactly one cycle, and rdata is only
// meaningful in that cycle. wstrobe != 0 marks a write, otherwise a read.
// irq is a level interrupt from the responder.
interface Bus;
    import Types_pkg::*;

    logic     valid;
    word_t    address;
    wstrobe_t wstrobe;
    word_t    wdata;
    logic     ready;
    word_t    rdata;
    logic     irq;

    // Responder end
    modport s (
        input  valid,
        input  address,
        input  wstrobe,
        input  wdata,
        output ready,
        output rdata,
        output irq
    );

    // Requester end
    modport m (
        output valid,
        output address,
        output wstrobe,
        output wdata,
        input  ready,
        input  rdata,
        input  irq
    );

endinterface

// File: rtl/bus_timer.sv
// Bus-attached 32-bit timer with CTRL/LIMIT/COUNT/STATUS registers.
// Optional feature: define BUS_TIMER_PRESCALER_EN to add an 8-bit prescaler
// whose reload value lives in CTRL[15:8]; without it the counter ticks on
// every enabled cycle and CTRL[15:8] reads as zero.
module bus_timer
    import Types_pkg::*;
#(
    parameter word_t RESET_LIMIT = 32'hFFFF_FFFF
) (
    input  logic clk,
    input  logic reset,
    Bus.s        bus
);

    // ---------------- state ----------------
    state_e state_q;
    logic   ready_q;
    word_t  rdata_q;

    logic   enable_q,      enable_d;
    logic   irq_en_q,      irq_en_d;
    logic   auto_reload_q, auto_reload_d;
    word_t  limit_q,       limit_d;
    word_t  count_q,       count_d;
    logic   event_q,       event_d;

`ifdef BUS_TIMER_PRESCALER_EN
    logic [7:0] presc_val_q, presc_val_d;
    logic [7:0] presc_cnt_q, presc_cnt_d;
`endif

    // ---------------- decode ----------------
    reg_idx_t sel;
    logic     access;
    logic     wr;
    logic     wr_ctrl;
    logic     wr_limit;
    logic     wr_count;
    logic     wr_status;
    logic     status_clear;
    logic     tick;
    logic     match;
    word_t    ctrl_word;
    word_t    status_word;
    word_t    rd_word;
    word_t    ctrl_wr_val;

    // A transaction is accepted only in IDLE; valid seen in RESP is ignored
    assign sel       = bus.address[3:2];
    assign access    = (state_q == ST_IDLE) && bus.valid;
    assign wr        = access && (bus.wstrobe != '0);
    assign wr_ctrl   = wr && (sel == REG_CTRL);
    assign wr_limit  = wr && (sel == REG_LIMIT);
    assign wr_count  = wr && (sel == REG_COUNT);
    assign wr_status = wr && (sel == REG_STATUS);

    // Write-1-to-clear on the event bit needs its lane enabled
    assign status_clear = wr_status && bus.wstrobe[0] && bus.wdata[STATUS_EVENT];

    // Assemble the architectural CTRL and STATUS words
    always_comb begin
        ctrl_word                   = '0;
        ctrl_word[CTRL_ENABLE]      = enable_q;
        ctrl_word[CTRL_IRQ_EN]      = irq_en_q;
        ctrl_word[CTRL_AUTO_RELOAD] = auto_reload_q;
`ifdef BUS_TIMER_PRESCALER_EN
        ctrl_word[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = presc_val_q;
`endif
        status_word               = '0;
        status_word[STATUS_EVENT] = event_q;
    end

    // Read mux: value of the selected register before any same-cycle write
    always_comb begin
        rd_word = '0;
        case (sel)
            REG_CTRL:   rd_word = ctrl_word;
            REG_LIMIT:  rd_word = limit_q;
            REG_COUNT:  rd_word = count_q;
            REG_STATUS: rd_word = status_word;
            default:    rd_word = '0;
        endcase
    end

    // Tick generation; with the prescaler a tick fires when its count reaches P
`ifdef BUS_TIMER_PRESCALER_EN
    assign tick = enable_q && (presc_cnt_q == presc_val_q);
`else
    assign tick = enable_q;
`endif

    assign match = tick && (count_q == limit_q);

    // Next-state logic for the timer registers; bus writes override the counter
    always_comb begin
        ctrl_wr_val   = merge_lanes(ctrl_word, bus.wdata, bus.wstrobe);

        enable_d      = enable_q;
        irq_en_d      = irq_en_q;
        auto_reload_d = auto_reload_q;
`ifdef BUS_TIMER_PRESCALER_EN
        presc_val_d   = presc_val_q;
`endif
        // One-shot mode stops itself on the match
        if (match && !auto_reload_q) begin
            enable_d = 1'b0;
        end
        if (wr_ctrl) begin
            enable_d      = ctrl_wr_val[CTRL_ENABLE];
            irq_en_d      = ctrl_wr_val[CTRL_IRQ_EN];
            auto_reload_d = ctrl_wr_val[CTRL_AUTO_RELOAD];
`ifdef BUS_TIMER_PRESCALER_EN
            presc_val_d   = ctrl_wr_val[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
`endif
        end

        // COUNT only returns to zero through a match; otherwise it stops at max
        count_d = count_q;
        if (tick) begin
            if (match) begin
                count_d = '0;
            end else if (count_q != COUNT_MAX) begin
                count_d = count_q + word_t'(1);
            end
        end
        if (wr_count) begin
            count_d = merge_lanes(count_q, bus.wdata, bus.wstrobe);
        end

        limit_d = wr_limit ? merge_lanes(limit_q, bus.wdata, bus.wstrobe) : limit_q;

        // A new event wins over a coincident clear
        event_d = (event_q && !status_clear) || match;

`ifdef BUS_TIMER_PRESCALER_EN
        if (!enable_q || wr_ctrl) begin
            presc_cnt_d = '0;
        end else if (presc_cnt_q == presc_val_q) begin
            presc_cnt_d = '0;
        end else begin
            presc_cnt_d = presc_cnt_q + 8'd1;
        end
`endif
    end

    // Timer register state
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q      <= 1'b0;
            irq_en_q      <= 1'b0;
            auto_reload_q <= 1'b0;
            limit_q       <= RESET_LIMIT;
            count_q       <= '0;
            event_q       <= 1'b0;
`ifdef BUS_TIMER_PRESCALER_EN
            presc_val_q   <= '0;
            presc_cnt_q   <= '0;
`endif
        end else begin
            enable_q      <= enable_d;
            irq_en_q      <= irq_en_d;
            auto_reload_q <= auto_reload_d;
            limit_q       <= limit_d;
            count_q       <= count_d;
            event_q       <= event_d;
`ifdef BUS_TIMER_PRESCALER_EN
            presc_val_q   <= presc_val_d;
            presc_cnt_q   <= presc_cnt_d;
`endif
        end
    end

    // Handshake FSM with registered ready/rdata: one wait state per access
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.valid) begin
                        state_q <= ST_RESP;
                        ready_q <= 1'b1;
                        rdata_q <= rd_word;
                    end else begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b0;
                        rdata_q <= '0;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
    assign bus.irq   = event_q & irq_en_q;

    // Address bits outside [3:2] are decoded upstream; CTRL holes are reserved
    logic unused_ok;
`ifdef BUS_TIMER_PRESCALER_EN
    assign unused_ok = &{1'b0, bus.address[31:4], bus.address[1:0],
                         ctrl_wr_val[31:16], ctrl_wr_val[7:3]};
`else
    assign unused_ok = &{1'b0, bus.address[31:4], bus.address[1:0],
                         ctrl_wr_val[31:3]};
`endif

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: a driver issues bus accesses and queues the
// hand-computed response; a negedge monitor pops and compares on every ready.
module tb_bus_timer;
    import Types_pkg::*;

`ifdef BUS_TIMER_PRESCALER_EN
    localparam bit PRESC = 1'b1;
`else
    localparam bit PRESC = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    Bus bus_if ();

    bus_timer #(.RESET_LIMIT(32'hFFFF_FFFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    bit          chk_q[$];
    string       name_q[$];
    int          checks = 0;
    int          fails  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: every ready pops one expected response; rdata must be 0 otherwise
    logic [31:0] mon_exp;
    bit          mon_chk;
    string       mon_name;
    always @(negedge clk) begin
        if (bus_if.ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_ready actual=ready rdata=%h expected=no response", bus_if.rdata);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_chk  = chk_q.pop_front();
                mon_name = name_q.pop_front();
                if (mon_chk) check(mon_name, bus_if.rdata, mon_exp);
            end
        end else begin
            check("rdata_idle_zero", bus_if.rdata, 32'h0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic xfer(input string nm, input reg_idx_t idx, input logic [3:0] strb,
                        input logic [31:0] data, input logic [31:0] exp, input bit chk);
        @(negedge clk);
        bus_if.valid   = 1'b1;
        bus_if.address = {28'hA5A5A5A, idx, 2'b11};
        bus_if.wstrobe = strb;
        bus_if.wdata   = data;
        exp_q.push_back(exp);
        chk_q.push_back(chk);
        name_q.push_back(nm);
        @(posedge clk);
        @(negedge clk);
        bus_if.valid   = 1'b0;
        bus_if.wstrobe = 4'h0;
        bus_if.wdata   = 32'h0;
        @(posedge clk);
    endtask

    task automatic rd(input string nm, input reg_idx_t idx, input logic [31:0] exp);
        xfer(nm, idx, 4'h0, 32'h0, exp, 1'b1);
    endtask

    task automatic wr(input string nm, input reg_idx_t idx, input logic [3:0] strb,
                      input logic [31:0] data, input logic [31:0] pre);
        xfer(nm, idx, strb, data, pre, 1'b1);
    endtask

    // Read with valid held high across RESP: two responses, two cycles apart
    task automatic rd_held2(input string nm, input reg_idx_t idx, input logic [31:0] exp);
        @(negedge clk);
        bus_if.valid   = 1'b1;
        bus_if.address = {28'h0000000, idx, 2'b00};
        bus_if.wstrobe = 4'h0;
        exp_q.push_back(exp); chk_q.push_back(1'b1); name_q.push_back({nm, "_a"});
        exp_q.push_back(exp); chk_q.push_back(1'b1); name_q.push_back({nm, "_b"});
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus_if.valid = 1'b0;
        @(posedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus_if.valid   = 1'b0;
        bus_if.address = 32'h0;
        bus_if.wstrobe = 4'h0;
        bus_if.wdata   = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'h0, bus_if.ready}, 32'h0);
        check("reset_rdata", bus_if.rdata, 32'h0);
        check("reset_irq", {31'h0, bus_if.irq}, 32'h0);
        reset = 1'b0;
        @(posedge clk);

        // Reset values, back-to-back reads with valid held
        rd_held2("limit_after_reset", REG_LIMIT, 32'hFFFF_FFFF);
        rd("ctrl_after_reset", REG_CTRL, 32'h0);
        rd("count_after_reset", REG_COUNT, 32'h0);
        rd("status_after_reset", REG_STATUS, 32'h0);

        // Prescale field presence
        wr("ctrl_field_wr", REG_CTRL, 4'hF, 32'h0000_FF06, 32'h0);
        rd("ctrl_field_rd", REG_CTRL, PRESC ? 32'h0000_FF06 : 32'h0000_0006);
        wr("ctrl_field_clr", REG_CTRL, 4'hF, 32'h0, PRESC ? 32'h0000_FF06 : 32'h0000_0006);

        // Byte-lane writes
        wr("count_lane_wr", REG_COUNT, 4'b0011, 32'h1234_5678, 32'h0);
        rd("count_lane_rd", REG_COUNT, 32'h0000_5678);
        wr("limit_lane_wr", REG_LIMIT, 4'b1100, 32'hAABB_CCDD, 32'hFFFF_FFFF);
        rd("limit_lane_rd", REG_LIMIT, 32'hAABB_FFFF);
        wr("count_zero", REG_COUNT, 4'hF, 32'h0, 32'h0000_5678);

        // Auto-reload with interrupt, LIMIT=3
        wr("ar_limit", REG_LIMIT, 4'hF, 32'h3, 32'hAABB_FFFF);
        wr("ar_ctrl", REG_CTRL, 4'hF, 32'h7, 32'h0);
        rd("ar_count_1", REG_COUNT, 32'h1);
        rd("ar_count_3", REG_COUNT, 32'h3);
        rd("ar_count_wrapped_1", REG_COUNT, 32'h1);
        #1 check("ar_irq_high", {31'h0, bus_if.irq}, 32'h1);
        rd("ar_status", REG_STATUS, 32'h1);
        wr("ar_disable", REG_CTRL, 4'hF, 32'h2, 32'h7);
        #1 check("ar_irq_still_high", {31'h0, bus_if.irq}, 32'h1);
        wr("ar_status_clr", REG_STATUS, 4'hF, 32'h1, 32'h1);
        #1 check("ar_irq_cleared", {31'h0, bus_if.irq}, 32'h0);
        rd("ar_status_after_clr", REG_STATUS, 32'h0);

        // One-shot, LIMIT=2, no interrupt
        xfer("os_count_zero", REG_COUNT, 4'hF, 32'h0, 32'h0, 1'b0);
        wr("os_limit", REG_LIMIT, 4'hF, 32'h2, 32'h3);
        wr("os_ctrl", REG_CTRL, 4'hF, 32'h1, 32'h2);
        rd("os_count_1", REG_COUNT, 32'h1);
        rd("os_ctrl_stopped", REG_CTRL, 32'h0);
        rd("os_count_0", REG_COUNT, 32'h0);
        rd("os_status", REG_STATUS, 32'h1);
        #1 check("os_irq_low", {31'h0, bus_if.irq}, 32'h0);
        wr("os_status_clr", REG_STATUS, 4'hF, 32'h1, 32'h1);
        rd("os_status_after_clr", REG_STATUS, 32'h0);

        // STATUS clear on the same edge as a match: the event survives
        wr("co_limit", REG_LIMIT, 4'hF, 32'h3, 32'h2);
        wr("co_ctrl", REG_CTRL, 4'hF, 32'h1, 32'h0);
        rd("co_count_1", REG_COUNT, 32'h1);
        wr("co_status_clr_at_match", REG_STATUS, 4'hF, 32'h1, 32'h0);
        rd("co_status_set_wins", REG_STATUS, 32'h1);
        rd("co_ctrl_stopped", REG_CTRL, 32'h0);
        rd("co_count_0", REG_COUNT, 32'h0);
        wr("co_status_clr", REG_STATUS, 4'hF, 32'h1, 32'h1);

        // COUNT above LIMIT stops at all-ones rather than wrapping
        wr("sat_limit", REG_LIMIT, 4'hF, 32'h5, 32'h3);
        wr("sat_count", REG_COUNT, 4'hF, 32'hFFFF_FFFE, 32'h0);
        wr("sat_ctrl", REG_CTRL, 4'hF, 32'h1, 32'h0);
        rd("sat_count_max_a", REG_COUNT, 32'hFFFF_FFFF);
        rd("sat_count_max_b", REG_COUNT, 32'hFFFF_FFFF);
        wr("sat_disable", REG_CTRL, 4'hF, 32'h0, 32'h1);
        rd("sat_no_event", REG_STATUS, 32'h0);
        wr("sat_count_zero", REG_COUNT, 4'hF, 32'h0, 32'hFFFF_FFFF);

`ifdef BUS_TIMER_PRESCALER_EN
        // Prescale P=3, LIMIT=1: COUNT steps every 4 cycles, event at cycle 8
        wr("ps_limit", REG_LIMIT, 4'hF, 32'h1, 32'h5);
        wr("ps_ctrl", REG_CTRL, 4'hF, 32'h0000_0301, 32'h0);
        rd("ps_count_c2", REG_COUNT, 32'h0);
        rd("ps_count_c4", REG_COUNT, 32'h0);
        rd("ps_count_c6", REG_COUNT, 32'h1);
        rd("ps_status_c8", REG_STATUS, 32'h0);
        rd("ps_status_c10", REG_STATUS, 32'h1);
        rd("ps_ctrl_stopped", REG_CTRL, 32'h0000_0300);
        wr("ps_status_clr", REG_STATUS, 4'hF, 32'h1, 32'h1);
        wr("ps_ctrl_clr", REG_CTRL, 4'hF, 32'h0, 32'h0000_0300);
`endif

        // Reset while ready is high abandons the access
        wr("rst_ctrl", REG_CTRL, 4'hF, 32'h6, 32'h0);
        wr("rst_count", REG_COUNT, 4'hF, 32'h5, 32'h0);
        @(negedge clk);
        bus_if.valid   = 1'b1;
        bus_if.address = {28'h0, REG_LIMIT, 2'b00};
        bus_if.wstrobe = 4'h0;
        exp_q.push_back(PRESC ? 32'h1 : 32'h5);
        chk_q.push_back(1'b1);
        name_q.push_back("rst_read_limit");
        @(posedge clk);
        @(negedge clk);
        bus_if.valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 check("rst_ready_drop", {31'h0, bus_if.ready}, 32'h0);
        check("rst_rdata_zero", bus_if.rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        rd("rst_ctrl_rd", REG_CTRL, 32'h0);
        rd("rst_limit_rd", REG_LIMIT, 32'hFFFF_FFFF);
        rd("rst_count_rd", REG_COUNT, 32'h0);
        rd("rst_status_rd", REG_STATUS, 32'h0);
        #1 check("rst_irq", {31'h0, bus_if.irq}, 32'h0);

        repeat (3) @(negedge clk);
        check("responses_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 Parameter: RESET_LIMIT, 32'hFFFF_FFFF, LIMIT register value after reset.
REQ-002 Port: clk  input  1  sole clock, all state on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: bus  Bus.s modport  --  responder end of the Bus interface: valid/address/wstrobe(4)/wdata(32) in; ready/rdata(32)/irq out.
REQ-005 One clock; reset is synchronous and active-high; ports named clk and reset.

Function
REQ-006 Register select SHALL be address[3:2]: 0 CTRL, 1 LIMIT, 2 COUNT, 3 STATUS; other address bits ignored (decode done upstream).
REQ-007 CTRL bits: [0] enable, [1] irq_en, [2] auto_reload; unused bits read 0.
REQ-008 STATUS bit [0] event; write-1-to-clear; other bits read 0.
REQ-009 Access SHALL be a write when wstrobe != 0, a read otherwise; writes honour each byte lane of wstrobe independently.
REQ-010 Handshake FSM SHALL have states IDLE and RESP; IDLE & valid -> RESP; RESP -> IDLE unconditionally; IDLE & !valid -> IDLE.
REQ-011 In the IDLE cycle with valid high, the write SHALL be applied at that clock edge and the pre-write register value captured into rdata.
REQ-012 ready SHALL be 1 exactly in RESP (one wait state, latency 1 cycle); rdata valid only while ready=1, held 0 otherwise.
REQ-013 valid high during RESP SHALL be ignored; a valid still high on return to IDLE starts a new transaction (max one access per 2 cycles).
REQ-014 When enable=1, COUNT SHALL increment by 1 per tick (every cycle, or per prescaler tick if REQ-022 compiled in).
REQ-015 On a tick where COUNT == LIMIT: event <= 1; COUNT <= 0; if auto_reload=0, enable <= 0.
REQ-016 COUNT wraps 32'hFFFF_FFFF -> 0 only via REQ-015 (LIMIT = all-ones); no other wrap.
REQ-017 Software write to COUNT or CTRL in the same cycle as a tick/match SHALL take priority over the counter update (match event still sets event).
REQ-018 STATUS clear and event set in the same cycle: set SHALL win.
REQ-019 irq SHALL be registered-free combinational event & irq_en, level-sensitive until cleared.

Reset
REQ-020 On reset: FSM IDLE, ready=0, rdata=0, CTRL=0, COUNT=0, event=0, irq=0, LIMIT=RESET_LIMIT, prescaler state 0.
REQ-021 Reset in RESP SHALL abandon the transaction: ready=0 next cycle, no further response issued.

Configuration
REQ-022 Macro BUS_TIMER_PRESCALER_EN defined: CTRL[15:8] is an 8-bit prescale value P; an internal 8-bit counter generates one tick every P+1 enabled cycles; counter clears on any CTRL write and when enable=0.
REQ-023 Macro undefined: tick every enabled cycle; CTRL[15:8] reads 0 and writes ignored; no prescaler flops.

Structure
REQ-024 Register index constants (CTRL/LIMIT/COUNT/STATUS), CTRL bit positions and the FSM state enum SHALL live in Types_pkg alongside word_t and wstrobe_t.
REQ-025 Single module, no sub-modules; byte-lane write merge as a package function in Types_pkg.

Verification
REQ-026 Read LIMIT after reset (valid=1, address=4, wstrobe=0) -> ready=1 one cycle later, rdata=32'hFFFF_FFFF, ready=0 following cycle.
REQ-027 Write LIMIT=3, CTRL=32'h7 (enable, irq_en, auto_reload) -> COUNT 0,1,2,3,0...; event and irq rise on the cycle after COUNT==3 tick; write STATUS=1 -> irq=0 next cycle.
REQ-028 LIMIT=2, CTRL=32'h1 (no auto_reload) -> one event, COUNT=0, CTRL reads 32'h0 afterwards, irq stays 0 (irq_en=0).
REQ-029 Write COUNT=32'h1234_5678 with wstrobe=4'b0011 over COUNT=0 (disabled) -> read back 32'h0000_5678.
REQ-030 Assert reset while ready=1 -> ready=0 next cycle, all registers at REQ-020 values; STATUS clear coincident with match -> STATUS reads 1.
REQ-031 With BUS_TIMER_PRESCALER_EN, CTRL=32'h0000_0301, LIMIT=1 -> COUNT increments every 4 cycles, event after 8 enabled cycles.
